zero_sequence_generator: RTL and testbench
==========================================

ZERO_SEQUENCE_GENERATOR -- requirements
Module: zero_sequence_generator

Interface
REQ-001 SHALL have parameter MAX_LEN, default 9, which is the longest run emitted (legal range 1..15).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, which is the number of low cycles forced after each run (legal range 1..15).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_NOT_RESET, input, 1 bit: reset, synchronous and active-high, despite the name.
REQ-005 SHALL have port i_VALID, input, 1 bit: run request present.
REQ-006 SHALL have port i_LEN, input, 4 bits: requested run length in cycles.
REQ-007 SHALL have port i_ABORT, input, 1 bit: cancel the run or gap in progress.
REQ-008 SHALL have port o_READY, output, 1 bit: the block can accept a request.
REQ-009 SHALL have port o_out, output, 1 bit: the serial run stream, suitable for driving a run-length counter's enable.
REQ-010 SHALL have port o_BUSY, output, 1 bit: a run or gap is in progress.
REQ-011 SHALL have port o_DONE, output, 1 bit: single-cycle pulse marking request completion.
REQ-012 SHALL have port o_CLAMP, output, 1 bit: single-cycle pulse flagging that i_LEN exceeded MAX_LEN.
REQ-013 SHALL have port o_MAX, output, 4 bits: the longest run emitted since reset (present only with ZSG_MAXTRACK_EN).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, GAP.
REQ-015 SHALL drive o_READY=1 only in IDLE; a request is accepted on a cycle where i_VALID and o_READY are both 1.
REQ-016 SHALL register the effective length on acceptance: L = min(i_LEN, MAX_LEN).
REQ-017 SHALL pulse o_CLAMP in the cycle after acceptance when i_LEN > MAX_LEN.
REQ-018 SHALL handle i_LEN=0 as follows: the request is accepted, the FSM stays in IDLE, o_out stays 0, and o_DONE pulses in the next cycle.
REQ-019 SHALL, for L>=1 accepted at cycle N, move to RUN and hold o_out=1 for exactly cycles N+1..N+L.
REQ-020 SHALL, after the last RUN cycle, move to GAP and hold o_out=0 for exactly GAP_CYCLES cycles.
REQ-021 SHALL assert o_DONE during the last GAP cycle; the FSM returns to IDLE on the next cycle, where o_READY=1.
REQ-022 SHALL keep back-to-back throughput at one request per L+GAP_CYCLES+1 cycles; a request held on i_VALID is accepted in the first IDLE cycle.
REQ-023 SHALL drive o_BUSY=1 exactly in RUN and GAP, and o_out=0 in IDLE and GAP.
REQ-024 SHALL keep the run and gap counters at 4 bits, with no wrap-around: the run counter counts down from L and the transition is taken at value 1.
REQ-025 SHALL, when i_ABORT=1 in RUN or GAP, enter IDLE on the next edge with o_out=0 and no o_DONE pulse.
REQ-026 SHALL ignore i_ABORT in IDLE.
REQ-027 SHALL give i_ABORT priority over completion when both occur in the same cycle.
REQ-028 SHALL give reset priority over i_ABORT, i_VALID and all state transitions.

Reset
REQ-029 SHALL, with i_NOT_RESET=1 at a rising edge, put the FSM in IDLE, clear all counters, and set o_out=0, o_BUSY=0, o_DONE=0, o_CLAMP=0 and o_MAX=0.
REQ-030 SHALL drive o_READY=1 on the first cycle after reset is released.
REQ-031 SHALL discard a run that is in progress when reset is asserted, emitting no o_DONE.

Configuration
REQ-032 SHALL compile the o_MAX port and its tracking register in only when macro ZSG_MAXTRACK_EN is defined.
REQ-033 SHALL, with ZSG_MAXTRACK_EN defined, update o_MAX to L when a run completes naturally with L > o_MAX; aborted runs and L=0 requests do not update it.
REQ-034 SHALL, without ZSG_MAXTRACK_EN, have no o_MAX port, with all other behaviour identical.

Verification
REQ-035 SHALL cover a basic run: i_LEN=3 accepted at cycle 0 -> o_out=1 in cycles 1-3, 0 in cycle 4, o_DONE=1 in cycle 4, o_READY=1 in cycle 5.
REQ-036 SHALL cover clamping: i_LEN=12 with MAX_LEN=9 -> o_CLAMP pulses once and o_out is high for exactly 9 cycles.
REQ-037 SHALL cover a zero-length request: i_LEN=0 -> o_out never rises, o_DONE pulses in the next cycle, and o_BUSY stays 0.
REQ-038 SHALL cover abort: i_ABORT=1 in the 2nd RUN cycle of a 5-cycle run -> o_out=0 and o_READY=1 on the next cycle, and no o_DONE.
REQ-039 SHALL cover back-to-back requests and MAX tracking: i_VALID held high with lengths 2, 5, 4 and GAP_CYCLES=2 -> requests are accepted at cycles 0, 5 and 13, and with ZSG_MAXTRACK_EN o_MAX ends at 5.
REQ-040 SHALL cover reset mid-run: i_NOT_RESET=1 in cycle 2 of a 6-cycle run -> all outputs are at reset values on the next cycle, and no o_DONE pulse appears.

Source files
------------

// File: rtl/zero_sequence_generator.sv
// rtl/zero_sequence_generator.sv - serial run generator: IDLE/RUN/GAP FSM emitting a high run of L cycles then a forced low gap.
// Optional o_MAX longest-run tracker compiled in with ZSG_MAXTRACK_EN.
module zero_sequence_generator #(
    parameter int MAX_LEN    = 9,
    parameter int GAP_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_NOT_RESET,
    input  logic       i_VALID,
    input  logic [3:0] i_LEN,
    input  logic       i_ABORT,
    output logic       o_READY,
    output logic       o_out,
    output logic       o_BUSY,
    output logic       o_DONE,
    output logic       o_CLAMP
`ifdef ZSG_MAXTRACK_EN
    ,
    output logic [3:0] o_MAX
`endif
);

    localparam logic [3:0] MAX_L = 4'(MAX_LEN);
    localparam logic [3:0] GAP_L = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [3:0] run_cnt, run_n;
    logic [3:0] gap_cnt, gap_n;
    logic       zdone_q, zdone_n;
    logic       clamp_q, clamp_n;
    logic [3:0] eff_len;
    logic       complete;

    always_ff @(posedge i_clk) begin
        if (i_NOT_RESET) begin
            state   <= IDLE;
            run_cnt <= 4'd0;
            gap_cnt <= 4'd0;
            zdone_q <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            state   <= state_n;
            run_cnt <= run_n;
            gap_cnt <= gap_n;
            zdone_q <= zdone_n;
            clamp_q <= clamp_n;
        end
    end

    always_comb begin
        state_n  = state;
        run_n    = run_cnt;
        gap_n    = gap_cnt;
        zdone_n  = 1'b0;
        clamp_n  = 1'b0;
        complete = 1'b0;
        eff_len  = (i_LEN > MAX_L) ? MAX_L : i_LEN;
        case (state)
            IDLE: begin
                if (i_VALID) begin
                    clamp_n = (i_LEN > MAX_L);
                    if (eff_len == 4'd0) begin
                        zdone_n = 1'b1;
                    end else begin
                        state_n = RUN;
                        run_n   = eff_len;
                    end
                end
            end
            RUN: begin
                if (i_ABORT) begin
                    state_n = IDLE;
                    run_n   = 4'd0;
                end else if (run_cnt == 4'd1) begin
                    state_n = GAP;
                    run_n   = 4'd0;
                    gap_n   = GAP_L;
                end else begin
                    run_n = run_cnt - 4'd1;
                end
            end
            GAP: begin
                if (i_ABORT) begin
                    state_n = IDLE;
                    gap_n   = 4'd0;
                end else if (gap_cnt == 4'd1) begin
                    state_n  = IDLE;
                    gap_n    = 4'd0;
                    // A reset landing on the final gap cycle discards the run, so no completion.
                    complete = ~i_NOT_RESET;
                end else begin
                    gap_n = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                run_n   = 4'd0;
                gap_n   = 4'd0;
            end
        endcase
    end

    assign o_READY = (state == IDLE);
    assign o_BUSY  = (state == RUN) || (state == GAP);
    assign o_out   = (state == RUN);
    assign o_DONE  = zdone_q | complete;
    assign o_CLAMP = clamp_q;

`ifdef ZSG_MAXTRACK_EN
    logic [3:0] len_q;
    logic [3:0] max_q;

    always_ff @(posedge i_clk) begin
        if (i_NOT_RESET) begin
            len_q <= 4'd0;
            max_q <= 4'd0;
        end else begin
            if (state == IDLE && i_VALID) begin
                len_q <= eff_len;
            end
            if (complete && len_q > max_q) begin
                max_q <= len_q;
            end
        end
    end

    assign o_MAX = max_q;
`endif

endmodule

// File: tb/tb_zero_sequence_generator.sv
// tb/tb_zero_sequence_generator.sv - self-checking bench: two instances (GAP 1 and 2) against a cycle-indexed model.
module tb_zero_sequence_generator;

    localparam int MAXL = 9;

    logic       i_clk;
    logic       i_NOT_RESET;
    logic       i_VALID;
    logic [3:0] i_LEN;
    logic       i_ABORT;
    logic [1:0] rdy, outw, busy, done, clamp;
    logic [3:0] mx0, mx1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    // Model: each instance is either idle or serving a request accepted at m_acc with length m_len.
    int gcyc [2] = '{1, 2};
    int m_act[2], m_acc[2], m_len[2], m_zd[2], m_cl[2], m_max[2];
    int m_eff;

    zero_sequence_generator #(.MAX_LEN(MAXL), .GAP_CYCLES(1)) dut0 (
        .i_clk(i_clk), .i_NOT_RESET(i_NOT_RESET), .i_VALID(i_VALID), .i_LEN(i_LEN),
        .i_ABORT(i_ABORT), .o_READY(rdy[0]), .o_out(outw[0]), .o_BUSY(busy[0]),
        .o_DONE(done[0]), .o_CLAMP(clamp[0])
`ifdef ZSG_MAXTRACK_EN
        , .o_MAX(mx0)
`endif
    );

    zero_sequence_generator #(.MAX_LEN(MAXL), .GAP_CYCLES(2)) dut1 (
        .i_clk(i_clk), .i_NOT_RESET(i_NOT_RESET), .i_VALID(i_VALID), .i_LEN(i_LEN),
        .i_ABORT(i_ABORT), .o_READY(rdy[1]), .o_out(outw[1]), .o_BUSY(busy[1]),
        .o_DONE(done[1]), .o_CLAMP(clamp[1])
`ifdef ZSG_MAXTRACK_EN
        , .o_MAX(mx1)
`endif
    );

`ifndef ZSG_MAXTRACK_EN
    assign mx0 = 4'd0;
    assign mx1 = 4'd0;
`endif

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_acc[k] = 0; m_len[k] = 0;
            m_zd[k] = -1; m_cl[k] = -1; m_max[k] = 0;
        end
        forever begin
            @(posedge i_clk);
            for (int k = 0; k < 2; k++) begin
                if (i_NOT_RESET) begin
                    m_act[k] = 0; m_zd[k] = -1; m_cl[k] = -1; m_max[k] = 0;
                end else if (m_act[k] != 0) begin
                    if (i_ABORT) begin
                        m_act[k] = 0;
                    end else if (cyc == m_acc[k] + m_len[k] + gcyc[k]) begin
                        m_act[k] = 0;
                        if (m_len[k] > m_max[k]) m_max[k] = m_len[k];
                    end
                end else if (i_VALID) begin
                    m_eff = (int'(i_LEN) > MAXL) ? MAXL : int'(i_LEN);
                    if (int'(i_LEN) > MAXL) m_cl[k] = cyc + 1;
                    if (m_eff == 0) begin
                        m_zd[k] = cyc + 1;
                    end else begin
                        m_act[k] = 1; m_acc[k] = cyc; m_len[k] = m_eff;
                    end
                end
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (chk_en) begin
                for (int k = 0; k < 2; k++) begin
                    int e_out, e_done, e_endc;
                    e_endc = m_acc[k] + m_len[k] + gcyc[k];
                    e_out  = (m_act[k] != 0 && cyc <= m_acc[k] + m_len[k]) ? 1 : 0;
                    e_done = ((m_act[k] != 0 && cyc == e_endc && !i_ABORT && !i_NOT_RESET)
                              || m_zd[k] == cyc) ? 1 : 0;
                    chk($sformatf("i%0d_c%0d_out", k, cyc), int'(outw[k]), e_out);
                    chk($sformatf("i%0d_c%0d_busy", k, cyc), int'(busy[k]), m_act[k]);
                    chk($sformatf("i%0d_c%0d_ready", k, cyc), int'(rdy[k]), (m_act[k] != 0) ? 0 : 1);
                    chk($sformatf("i%0d_c%0d_done", k, cyc), int'(done[k]), e_done);
                    chk($sformatf("i%0d_c%0d_clamp", k, cyc), int'(clamp[k]), (m_cl[k] == cyc) ? 1 : 0);
`ifdef ZSG_MAXTRACK_EN
                    chk($sformatf("i%0d_c%0d_max", k, cyc), (k == 0) ? int'(mx0) : int'(mx1), m_max[k]);
`endif
                end
            end
        end
    end

    task automatic tick(input logic v, input logic [3:0] l, input logic ab, input logic r);
        @(posedge i_clk);
        #1;
        i_VALID = v; i_LEN = l; i_ABORT = ab; i_NOT_RESET = r;
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    int cnt_a, cnt_b, cnt_c, idx;
    int acc_at[3];
    logic [3:0] lens[3];

    initial begin
        i_VALID = 1'b0; i_LEN = 4'd0; i_ABORT = 1'b0; i_NOT_RESET = 1'b1;
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        chk_en = 1;
        chk("rst_out", int'(outw[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_clamp", int'(clamp[0]), 0);
        chk("rst_max", int'(mx0), 0);
        tick(1'b0, 4'd0, 1'b0, 1'b0);
        chk("rst_ready_after", int'(rdy[0]), 1);

        // Basic run, L=3, GAP=1
        tick(1'b1, 4'd3, 1'b0, 1'b0);
        chk("basic_ready_c0", int'(rdy[0]), 1);
        tick(1'b0, 4'd0, 1'b0, 1'b0); chk("basic_out_c1", int'(outw[0]), 1);
        tick(1'b0, 4'd0, 1'b0, 1'b0); chk("basic_out_c2", int'(outw[0]), 1);
        tick(1'b0, 4'd0, 1'b0, 1'b0); chk("basic_out_c3", int'(outw[0]), 1);
        tick(1'b0, 4'd0, 1'b0, 1'b0);
        chk("basic_out_c4", int'(outw[0]), 0);
        chk("basic_done_c4", int'(done[0]), 1);
        tick(1'b0, 4'd0, 1'b0, 1'b0); chk("basic_ready_c5", int'(rdy[0]), 1);
        idle(2);

        // Clamp: 12 -> 9
        tick(1'b1, 4'd12, 1'b0, 1'b0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 13; i++) begin
            tick(1'b0, 4'd0, 1'b0, 1'b0);
            cnt_a += int'(outw[0]);
            cnt_b += int'(clamp[0]);
        end
        chk("clamp_high_cycles", cnt_a, 9);
        chk("clamp_pulses", cnt_b, 1);
        idle(1);

        // Zero-length request
        tick(1'b1, 4'd0, 1'b0, 1'b0);
        cnt_a = int'(busy[0]); cnt_b = int'(done[0]); cnt_c = int'(outw[0]);
        tick(1'b0, 4'd0, 1'b0, 1'b0);
        chk("zero_done_next", int'(done[0]), 1);
        cnt_a += int'(busy[0]); cnt_b += int'(done[0]); cnt_c += int'(outw[0]);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 4'd0, 1'b0, 1'b0);
            cnt_a += int'(busy[0]); cnt_b += int'(done[0]); cnt_c += int'(outw[0]);
        end
        chk("zero_busy", cnt_a, 0);
        chk("zero_done_count", cnt_b, 1);
        chk("zero_out", cnt_c, 0);

        // Abort in 2nd RUN cycle of a 5-cycle run
        tick(1'b1, 4'd5, 1'b0, 1'b0); cnt_a = int'(done[0]);
        tick(1'b0, 4'd0, 1'b0, 1'b0); cnt_a += int'(done[0]);
        tick(1'b0, 4'd0, 1'b1, 1'b0); cnt_a += int'(done[0]);
        chk("abort_out_c2", int'(outw[0]), 1);
        tick(1'b0, 4'd0, 1'b0, 1'b0); cnt_a += int'(done[0]);
        chk("abort_out_c3", int'(outw[0]), 0);
        chk("abort_ready_c3", int'(rdy[0]), 1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 4'd0, 1'b0, 1'b0); cnt_a += int'(done[0]);
        end
        chk("abort_no_done", cnt_a, 0);

        // Back-to-back on GAP=2 instance, fresh from reset
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        tick(1'b0, 4'd0, 1'b0, 1'b0);
        lens[0] = 4'd2; lens[1] = 4'd5; lens[2] = 4'd4;
        idx = 0;
        for (int t = 0; t < 40; t++) begin
            logic v;
            v = (idx < 3);
            tick(v, v ? lens[idx] : 4'd0, 1'b0, 1'b0);
            if (v && rdy[1]) begin
                acc_at[idx] = t;
                idx++;
            end
        end
        chk("b2b_accepts", idx, 3);
        if (idx == 3) begin
            chk("b2b_acc0", acc_at[0], 0);
            chk("b2b_acc1", acc_at[1], 5);
            chk("b2b_acc2", acc_at[2], 13);
        end
`ifdef ZSG_MAXTRACK_EN
        chk("b2b_max", int'(mx1), 5);
`endif

        // Reset in cycle 2 of a 6-cycle run
        tick(1'b1, 4'd6, 1'b0, 1'b0); cnt_a = int'(done[0]) + int'(done[1]);
        tick(1'b0, 4'd0, 1'b0, 1'b0); cnt_a += int'(done[0]) + int'(done[1]);
        tick(1'b0, 4'd0, 1'b0, 1'b1); cnt_a += int'(done[0]) + int'(done[1]);
        chk("rstmid_out_c2", int'(outw[0]), 1);
        tick(1'b0, 4'd0, 1'b0, 1'b0); cnt_a += int'(done[0]) + int'(done[1]);
        chk("rstmid_out", int'(outw[0]), 0);
        chk("rstmid_busy", int'(busy[0]), 0);
        chk("rstmid_ready", int'(rdy[0]), 1);
        chk("rstmid_clamp", int'(clamp[0]), 0);
        chk("rstmid_max", int'(mx0), 0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 4'd0, 1'b0, 1'b0); cnt_a += int'(done[0]) + int'(done[1]);
        end
        chk("rstmid_no_done", cnt_a, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            tick(($urandom % 3) != 0, 4'($urandom_range(0, 15)),
                 ($urandom % 12) == 0, ($urandom % 60) == 0);
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
